// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word-addressed SRAM with byte lanes and configurable wait states.
// Optional privileged-region check is enabled by defining AHB_SUB_PRIV_CHECK_EN.
module ahb_sram_subordinate #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] PRIV_BASE   = 32'h0000_0800
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  // state   | meaning
  // ST_IDLE | ready; completes a pending zero-wait or post-wait data phase
  // ST_WAIT | inserting wait states, counter runs down to 0
  // ST_ERR1 | first ERROR cycle, HREADYOUT low
  // ST_ERR2 | second ERROR cycle, HREADYOUT high

  localparam int NLANE = 4;
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * MEM_DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic             pend_valid_q;
  logic             pend_write_q;
  logic [IDX_W-1:0] pend_idx_q;
  logic [NLANE-1:0] pend_be_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept, take;
  logic [ADDR_WIDTH-1:0] addr_off;
  logic [IDX_W-1:0]      acc_idx;
  logic [NLANE-1:0]      acc_be;
  logic                  range_err, size_err, align_err, priv_err, acc_err;
  logic                  complete, wr_commit;
  logic                  rd_now_acc, rd_now_wait, rd_fire, fwd_hit;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_bits;

  function automatic logic [NLANE-1:0] lane_en(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      3'd0:    lane_en = 4'b0001 << lo;
      3'd1:    lane_en = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  endfunction

  assign accept   = HSEL && HREADY && HTRANS[1];
  assign take     = accept && ((state_q == ST_IDLE) || (state_q == ST_ERR2));
  assign addr_off = HADDR - BASE_ADDR;
  assign acc_idx  = addr_off[IDX_W+1:2];
  assign acc_be   = lane_en(HSIZE, HADDR[1:0]);

  assign range_err = ({1'b0, HADDR} < {1'b0, BASE_ADDR}) || ({1'b0, HADDR} >= ADDR_LIMIT);
  assign size_err  = (HSIZE > 3'd2);
  assign align_err = ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`ifdef AHB_SUB_PRIV_CHECK_EN
  assign priv_err  = (HADDR >= PRIV_BASE) && !HPROT[1];
`else
  assign priv_err  = 1'b0;
`endif
  assign acc_err   = range_err || size_err || align_err || priv_err;

  assign unused_bits = ^{HBURST, HPROT, HTRANS[0], PRIV_BASE,
                         addr_off[ADDR_WIDTH-1:IDX_W+2], addr_off[1:0]};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (take) begin
          if (acc_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  // A pending phase only completes in IDLE; errored transfers never become pending.
  assign complete  = (state_q == ST_IDLE) && pend_valid_q;
  assign wr_commit = complete && pend_write_q && !HRESET;

  assign rd_now_acc  = take && !acc_err && !HWRITE && (WAIT_STATES == 0);
  assign rd_now_wait = (state_q == ST_WAIT) && (cnt_q == 4'd0) && pend_valid_q && !pend_write_q;
  assign rd_fire     = rd_now_acc || rd_now_wait;
  assign rd_idx      = rd_now_wait ? pend_idx_q : acc_idx;
  assign fwd_hit     = wr_commit && (pend_idx_q == rd_idx);

  // Merge lanes being written on this same edge so the read sees post-write contents.
  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < NLANE; i++) begin
      if (fwd_hit && pend_be_q[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_valid_q <= 1'b0;
      pend_write_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_be_q    <= '0;
      rdata_q      <= '0;
    end else begin
      if (take) begin
        pend_valid_q <= !acc_err;
        pend_write_q <= HWRITE;
        pend_idx_q   <= acc_idx;
        pend_be_q    <= acc_be;
      end else if (complete) begin
        pend_valid_q <= 1'b0;
      end
      if (rd_fire) rdata_q <= rd_word;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_commit) begin
      for (int i = 0; i < NLANE; i++) begin
        if (pend_be_q[i]) mem[pend_idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA = rdata_q;

endmodule

// File: doc/ahb_sram_subordinate.md
Name: ahb_sram_subordinate

Overview:
- AHB-Lite subordinate (responder) fronting a single-port word-addressed SRAM array.
- It is the far end of the bus driven by the team's AHB manager. It sits behind the interconnect decoder and HREADY mux, selected via HSEL.
- It accepts pipelined address/data phases and inserts a configurable number of wait states.
- It supports byte, halfword and word accesses and issues two-cycle ERROR responses.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HRDATA/HWDATA width. Only 32 is supported.
- MEM_DEPTH, 1024, number of 32-bit words. Must be a power of 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY transfer (0..15).
- PRIV_BASE, 32'h0000_0800, first byte address of the privileged region. Used only with the optional feature.

Ports:
- HCLK  in  1  bus clock. Every register updates on the rising edge.
- HRESET  in  1  synchronous reset, active-high.
- HSEL  in  1  subordinate select from the decoder.
- HADDR  in  ADDR_WIDTH  byte address (address phase).
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word.
- HBURST  in  3  ignored, because every beat carries a full address.
- HPROT  in  4  protection; bit 1 = privileged.
- HWDATA  in  DATA_WIDTH  write data (data phase).
- HREADY  in  1  bus-wide ready from the mux.
- HREADYOUT  out  1  this subordinate's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data.

Behaviour:
- Transfer acceptance: a transfer is accepted on an edge where HSEL && HREADY && HTRANS[1]==1. HADDR, HWRITE, HSIZE and HPROT are registered as the pending data-phase control. IDLE or BUSY, or HSEL=0, yields an OKAY data phase with zero wait and no access.
- Error conditions, evaluated at acceptance:
  - HADDR < BASE_ADDR, or HADDR >= BASE_ADDR + 4*MEM_DEPTH.
  - HSIZE > 2.
  - Halfword with HADDR[0]=1.
  - Word with HADDR[1:0]!=0.
- An errored transfer performs no memory access.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. On accept: error goes to ERR1; else WAIT_STATES>0 goes to WAIT with the counter set to WAIT_STATES-1; else stays IDLE, with a zero-wait data phase in the next cycle.
  - WAIT: HREADYOUT=0, HRESP=0. The counter decrements each cycle. At 0, the next cycle is the completing cycle, with HREADYOUT=1, and the FSM returns to IDLE, where a new accept may occur the same cycle.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Goes to IDLE; a new accept may occur the same edge.
- Reads:
  - The array is read synchronously at the accept edge, or at the last WAIT edge when WAIT_STATES>0.
  - HRDATA is valid in the completing cycle (HREADYOUT=1) and holds its value until the next read completes.
  - Byte and halfword reads return the full aligned word; the manager selects the lanes.
- Writes:
  - Committed at the edge ending the completing data-phase cycle, using HWDATA from that cycle.
  - Lane enables, little-endian: a byte access enables lane HADDR[1:0]; a halfword enables lanes {HADDR[1],0} and {HADDR[1],1}; a word enables all four. Unenabled lanes are preserved.
- Read-after-write hazard: if a read is accepted on the same edge that commits a write to the same word, the written lanes are forwarded into HRDATA and the other lanes come from the array. HRDATA must equal post-write contents.
- Latency: read data at accept+1+WAIT_STATES cycles. Back-to-back OKAY transfers sustain 1 transfer per 1+WAIT_STATES cycles.
- Reset (HRESET=1 at an edge, including mid-transfer):
  - FSM goes to IDLE, the counter clears, pending control is cleared, and the pending write is dropped.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - Array contents are not cleared.
- Error timing: HRESP must never change while HREADYOUT=1, except on entry to IDLE after ERR2.

Optional Feature:
- Macro: AHB_SUB_PRIV_CHECK_EN.
- When defined: a transfer with HADDR >= PRIV_BASE and HPROT[1]==0 is an error condition and follows the ERR1/ERR2 path with no access.
- When undefined: HPROT is ignored, PRIV_BASE is unused, and no extra logic is generated.

Test Plan:
- Word write, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> the write completes 1 cycle after accept; the read returns 0xDEADBEEF via forwarding, HRESP=0.
- Byte lane writes: word 0x11223344 at 0x20, then byte 0xAA at 0x21, then halfword 0xBBCC at 0x22 -> reading 0x20 returns 0xBBCCAA44.
- WAIT_STATES=3, read 0x40 -> HREADYOUT low exactly 3 cycles after accept, then high with the correct HRDATA; the next NONSEQ is held on the bus until accepted.
- Errors: word read at 0x02, HSIZE=3, and address BASE_ADDR+4*MEM_DEPTH -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, and memory is unchanged.
- IDLE/BUSY/HSEL=0 interleaved with transfers -> zero-wait OKAY, with no memory or HRDATA change; HRESET asserted during WAIT -> the next cycle has HREADYOUT=1, HRESP=0, HRDATA=0, and a pending write is not committed.
- With AHB_SUB_PRIV_CHECK_EN: user write (HPROT=0001) to 0x800 -> ERROR with no write; privileged write (HPROT=0011) to 0x800 -> OKAY and data stored.
